// File: rtl/cve2_wb_arbiter_if.sv
// Writeback arbiter bus bundle: execute result, LSU load issue/return, decode read
// addresses, and the register file write port.
interface cve2_wb_arbiter_if #(
  parameter int DataWidth = 32
);
  logic                 ex_valid_i;
  logic                 ex_ready_o;
  logic [4:0]           ex_waddr_i;
  logic [DataWidth-1:0] ex_wdata_i;
  logic                 ld_req_i;
  logic                 ld_ready_o;
  logic [4:0]           ld_waddr_i;
  logic                 ld_rvalid_i;
  logic [DataWidth-1:0] ld_rdata_i;
  logic                 ld_err_i;
  logic [4:0]           raddr_a_i;
  logic [4:0]           raddr_b_i;
  logic                 hazard_o;
  logic [4:0]           rf_waddr_o;
  logic [DataWidth-1:0] rf_wdata_o;
  logic                 rf_we_o;
  logic                 ld_err_o;
  logic                 proto_err_o;
  logic                 illegal_waddr_o;
  logic                 dbg_ld_pend_o;

  // Handshakes: a transfer happens on a rising edge where valid/req and the matching
  // ready are both high; valid/req may not depend on ready, ready may depend on state only.
  modport slave (
    input  ex_valid_i, ex_waddr_i, ex_wdata_i, ld_req_i, ld_waddr_i,
           ld_rvalid_i, ld_rdata_i, ld_err_i, raddr_a_i, raddr_b_i,
    output ex_ready_o, ld_ready_o, hazard_o, rf_waddr_o, rf_wdata_o, rf_we_o,
           ld_err_o, proto_err_o, illegal_waddr_o, dbg_ld_pend_o
  );

  modport master (
    output ex_valid_i, ex_waddr_i, ex_wdata_i, ld_req_i, ld_waddr_i,
           ld_rvalid_i, ld_rdata_i, ld_err_i, raddr_a_i, raddr_b_i,
    input  ex_ready_o, ld_ready_o, hazard_o, rf_waddr_o, rf_wdata_o, rf_we_o,
           ld_err_o, proto_err_o, illegal_waddr_o, dbg_ld_pend_o
  );
endinterface

// File: rtl/cve2_wb_arbiter.sv
// Writeback arbiter: load return owns the register file write port, a colliding
// execute result parks in a 1-entry skid buffer; raises decode hazard stalls.
module cve2_wb_arbiter #(
  parameter bit RV32E     = 1'b0,
  parameter int DataWidth = 32
) (
  input logic             clk_i,
  input logic             rst_i,
  cve2_wb_arbiter_if.slave bus
);

  typedef enum logic {LD_IDLE = 1'b0, LD_PEND = 1'b1} ld_state_e;

  ld_state_e            ld_state;
  logic [4:0]           pend_addr;
  logic                 skid_full;
  logic [4:0]           skid_addr;
  logic [DataWidth-1:0] skid_data;

  logic                 ld_pending;
  logic                 ld_ret;
  logic                 ld_ok;
  logic                 ex_acc;
  logic                 wr_req;
  logic [4:0]           sel_addr;
  logic [DataWidth-1:0] sel_data;
  logic                 illegal;

  assign ld_pending = (ld_state == LD_PEND);
  assign ld_ret     = bus.ld_rvalid_i & ld_pending;
  assign ld_ok      = ld_ret & ~bus.ld_err_i;
  assign ex_acc     = bus.ex_valid_i & ~skid_full;

  // Priority: load return, then skid drain, then a fresh execute result.
  always_comb begin
    wr_req   = 1'b0;
    sel_addr = bus.ex_waddr_i;
    sel_data = bus.ex_wdata_i;
    if (ld_ok) begin
      wr_req   = 1'b1;
      sel_addr = pend_addr;
      sel_data = bus.ld_rdata_i;
    end else if (skid_full) begin
      wr_req   = 1'b1;
      sel_addr = skid_addr;
      sel_data = skid_data;
    end else if (ex_acc) begin
      wr_req = 1'b1;
    end
  end

  assign illegal = wr_req & RV32E & sel_addr[4];

  assign bus.rf_waddr_o      = sel_addr;
  assign bus.rf_wdata_o      = sel_data;
  assign bus.rf_we_o         = wr_req & (sel_addr != 5'd0) & ~illegal;
  assign bus.illegal_waddr_o = illegal;
  assign bus.ld_err_o        = ld_ret & bus.ld_err_i;
  assign bus.proto_err_o     = bus.ld_rvalid_i & ~ld_pending;
  assign bus.ex_ready_o      = ~skid_full;
  assign bus.ld_ready_o      = ~ld_pending;
  assign bus.dbg_ld_pend_o   = ld_pending;

  // Still asserted in the return cycle: the register file only updates on the edge.
  assign bus.hazard_o =
      (ld_pending & (pend_addr != 5'd0) &
       ((bus.raddr_a_i == pend_addr) | (bus.raddr_b_i == pend_addr) |
        (bus.ex_valid_i & (bus.ex_waddr_i == pend_addr)))) |
      (skid_full & (skid_addr != 5'd0) &
       ((bus.raddr_a_i == skid_addr) | (bus.raddr_b_i == skid_addr)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ld_state  <= LD_IDLE;
      pend_addr <= 5'd0;
      skid_full <= 1'b0;
      skid_addr <= 5'd0;
      skid_data <= '0;
    end else begin
      case (ld_state)
        LD_IDLE: if (bus.ld_req_i) begin
          ld_state  <= LD_PEND;
          pend_addr <= bus.ld_waddr_i;
        end
        LD_PEND: if (bus.ld_rvalid_i) ld_state <= LD_IDLE;
        default: ld_state <= LD_IDLE;
      endcase

      // Skid only fills when a load return steals the port from an accepted ex;
      // ex is never accepted while the skid is full, so a drain cannot collide.
      if (ld_ok && ex_acc) begin
        skid_full <= 1'b1;
        skid_addr <= bus.ex_waddr_i;
        skid_data <= bus.ex_wdata_i;
      end else if (skid_full && !ld_ok) begin
        skid_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cve2_wb_arbiter.sv
// Directed bench for cve2_wb_arbiter: RV32I instance plus an RV32E instance fed the same stimulus.
module tb_cve2_wb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cve2_wb_arbiter_if #(.DataWidth(32)) a ();
  cve2_wb_arbiter_if #(.DataWidth(32)) b ();

  cve2_wb_arbiter #(.RV32E(1'b0), .DataWidth(32)) dut_a (.clk_i(clk), .rst_i(rst), .bus(a));
  cve2_wb_arbiter #(.RV32E(1'b1), .DataWidth(32)) dut_b (.clk_i(clk), .rst_i(rst), .bus(b));

  assign b.ex_valid_i  = a.ex_valid_i;
  assign b.ex_waddr_i  = a.ex_waddr_i;
  assign b.ex_wdata_i  = a.ex_wdata_i;
  assign b.ld_req_i    = a.ld_req_i;
  assign b.ld_waddr_i  = a.ld_waddr_i;
  assign b.ld_rvalid_i = a.ld_rvalid_i;
  assign b.ld_rdata_i  = a.ld_rdata_i;
  assign b.ld_err_i    = a.ld_err_i;
  assign b.raddr_a_i   = a.raddr_a_i;
  assign b.raddr_b_i   = a.raddr_b_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    a.ex_valid_i  = 1'b0;
    a.ex_waddr_i  = 5'd0;
    a.ex_wdata_i  = 32'd0;
    a.ld_req_i    = 1'b0;
    a.ld_waddr_i  = 5'd0;
    a.ld_rvalid_i = 1'b0;
    a.ld_rdata_i  = 32'd0;
    a.ld_err_i    = 1'b0;
    a.raddr_a_i   = 5'd0;
    a.raddr_b_i   = 5'd0;
  endtask

  // Advance one clock; inputs return to idle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic issue_ld(input logic [4:0] addr);
    a.ld_req_i   = 1'b1;
    a.ld_waddr_i = addr;
    tick();
  endtask

  initial begin
    clr();
    rst = 1'b1;
    tick();
    #1;
    chk("rst_ex_ready", a.ex_ready_o, 1);
    chk("rst_ld_ready", a.ld_ready_o, 1);
    chk("rst_hazard", a.hazard_o, 0);
    chk("rst_we", a.rf_we_o, 0);
    chk("rst_pulses", {a.ld_err_o, a.proto_err_o, a.illegal_waddr_o}, 0);
    rst = 1'b0;
    tick();

    // Load x5, response three cycles after issue.
    issue_ld(5'd5);
    #1 chk("ld5_ready_busy", a.ld_ready_o, 0);
    chk("ld5_dbg_pend", a.dbg_ld_pend_o, 1);
    tick();
    tick();
    a.ld_rvalid_i = 1'b1;
    a.ld_rdata_i  = 32'hDEADBEEF;
    #1 chk("ld5_we", a.rf_we_o, 1);
    chk("ld5_waddr", a.rf_waddr_o, 5);
    chk("ld5_wdata", a.rf_wdata_o, 32'hDEADBEEF);
    tick();
    #1 chk("ld5_ready_after", a.ld_ready_o, 1);
    chk("ld5_we_after", a.rf_we_o, 0);

    // Load return collides with execute result; ex goes to skid.
    issue_ld(5'd5);
    a.ld_rvalid_i = 1'b1;
    a.ld_rdata_i  = 32'h11;
    a.ex_valid_i  = 1'b1;
    a.ex_waddr_i  = 5'd6;
    a.ex_wdata_i  = 32'h22;
    #1 chk("col_ex_ready_n", a.ex_ready_o, 1);
    chk("col_waddr_n", a.rf_waddr_o, 5);
    chk("col_wdata_n", a.rf_wdata_o, 32'h11);
    chk("col_we_n", a.rf_we_o, 1);
    tick();
    #1 chk("col_ex_ready_n1", a.ex_ready_o, 0);
    chk("col_we_n1", a.rf_we_o, 1);
    chk("col_waddr_n1", a.rf_waddr_o, 6);
    chk("col_wdata_n1", a.rf_wdata_o, 32'h22);
    tick();
    #1 chk("col_ex_ready_n2", a.ex_ready_o, 1);
    chk("col_we_n2", a.rf_we_o, 0);

    // RAW hazard against pending load x7, and WAW via ex destination.
    issue_ld(5'd7);
    a.raddr_a_i = 5'd7;
    #1 chk("haz7_raw", a.hazard_o, 1);
    tick();
    a.raddr_b_i = 5'd3;
    a.ex_valid_i = 1'b1;
    a.ex_waddr_i = 5'd7;
    a.ex_wdata_i = 32'h77;
    #1 chk("haz7_waw", a.hazard_o, 1);
    a.ex_valid_i = 1'b0;
    #1 chk("haz7_none", a.hazard_o, 0);
    tick();
    a.raddr_a_i   = 5'd7;
    a.ld_rvalid_i = 1'b1;
    a.ld_rdata_i  = 32'h7777;
    #1 chk("haz7_ret", a.hazard_o, 1);
    chk("haz7_ret_waddr", a.rf_waddr_o, 7);
    tick();
    a.raddr_a_i = 5'd7;
    #1 chk("haz7_after", a.hazard_o, 0);

    // Load to x0: never a hazard, never written.
    issue_ld(5'd0);
    a.raddr_a_i = 5'd0;
    #1 chk("haz0", a.hazard_o, 0);
    a.ld_rvalid_i = 1'b1;
    a.ld_rdata_i  = 32'h1234;
    #1 chk("ld0_we", a.rf_we_o, 0);
    tick();

    // Execute writes to x0 and to x20 (illegal only on the RV32E instance).
    a.ex_valid_i = 1'b1;
    a.ex_waddr_i = 5'd0;
    a.ex_wdata_i = 32'h5;
    #1 chk("ex0_we", a.rf_we_o, 0);
    a.ex_waddr_i = 5'd20;
    a.ex_wdata_i = 32'h99;
    #1 chk("ex20_we_rv32i", a.rf_we_o, 1);
    chk("ex20_ill_rv32i", a.illegal_waddr_o, 0);
    chk("ex20_we_rv32e", b.rf_we_o, 0);
    chk("ex20_ill_rv32e", b.illegal_waddr_o, 1);
    tick();
    #1 chk("ex20_ill_clear", b.illegal_waddr_o, 0);

    // Load bus error, then an unsolicited response.
    issue_ld(5'd9);
    a.ld_rvalid_i = 1'b1;
    a.ld_err_i    = 1'b1;
    a.ld_rdata_i  = 32'hBAD;
    #1 chk("lderr_we", a.rf_we_o, 0);
    chk("lderr_pulse", a.ld_err_o, 1);
    chk("lderr_proto", a.proto_err_o, 0);
    tick();
    #1 chk("lderr_ready", a.ld_ready_o, 1);
    chk("lderr_clear", a.ld_err_o, 0);
    a.ld_rvalid_i = 1'b1;
    a.ld_rdata_i  = 32'h55;
    #1 chk("proto_pulse", a.proto_err_o, 1);
    chk("proto_we", a.rf_we_o, 0);
    tick();

    // Fill skid, then reset with skid full and a new load requested.
    issue_ld(5'd3);
    a.ld_rvalid_i = 1'b1;
    a.ld_rdata_i  = 32'h33;
    a.ex_valid_i  = 1'b1;
    a.ex_waddr_i  = 5'd4;
    a.ex_wdata_i  = 32'h44;
    tick();
    a.raddr_a_i = 5'd4;
    a.ld_req_i  = 1'b1;
    a.ld_waddr_i = 5'd8;
    #1 chk("skid_hazard", a.hazard_o, 1);
    chk("skid_ex_ready", a.ex_ready_o, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a.raddr_a_i = 5'd4;
    a.raddr_b_i = 5'd8;
    #1 chk("rstmid_ex_ready", a.ex_ready_o, 1);
    chk("rstmid_ld_ready", a.ld_ready_o, 1);
    chk("rstmid_hazard", a.hazard_o, 0);
    chk("rstmid_we", a.rf_we_o, 0);
    tick();

    // Reset while a load is pending: the late response is a protocol error.
    issue_ld(5'd10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a.ld_rvalid_i = 1'b1;
    a.ld_rdata_i  = 32'hAAAA;
    #1 chk("rstld_proto", a.proto_err_o, 1);
    chk("rstld_we", a.rf_we_o, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
